// File: rtl/alu_issue_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_issue_stage
// Purpose  : RV32I decode-and-issue stage feeding the ALU. Accepts fetched
//            instructions over valid/ready, reads rs1/rs2 from the register
//            file in the accept cycle, decodes OP / OP-IMM / LUI / AUIPC into
//            {operand A, operand B, ALU op, rd} and presents the result to
//            execute through a registered 2-entry skid buffer.
// Ports    : clk_i, rst_ni (async, active-low), flush_i
//            instr_valid_i / instr_ready_o / instr_i / pc_i  : upstream side
//            rs1_addr_o, rs2_addr_o, rs1_data_i, rs2_data_i  : register file
//            ex_valid_o / ex_ready_i, alu_a_o, alu_b_o, alu_op_o,
//            rd_addr_o, pc_o, illegal_o                      : execute side
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ALU_OP_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC_TAG = '0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic [31:0]             instr_i,
  input  logic [DATA_WIDTH-1:0]   pc_i,
  output logic [4:0]              rs1_addr_o,
  output logic [4:0]              rs2_addr_o,
  input  logic [DATA_WIDTH-1:0]   rs1_data_i,
  input  logic [DATA_WIDTH-1:0]   rs2_data_i,
  output logic                    ex_valid_o,
  input  logic                    ex_ready_i,
  output logic [DATA_WIDTH-1:0]   alu_a_o,
  output logic [DATA_WIDTH-1:0]   alu_b_o,
  output logic [ALU_OP_WIDTH-1:0] alu_op_o,
  output logic [4:0]              rd_addr_o,
  output logic [DATA_WIDTH-1:0]   pc_o,
  output logic                    illegal_o
);

  // --------------------------------------------------------------------------
  // ALU op encoding shared with the execute stage
  // --------------------------------------------------------------------------
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_add  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_sub  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_sll  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_slt  = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_sltu = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_xor  = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_srl  = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_sra  = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_or   = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] c_alu_and  = ALU_OP_WIDTH'(9);

  localparam logic [6:0] c_opc_op    = 7'b0110011;
  localparam logic [6:0] c_opc_imm   = 7'b0010011;
  localparam logic [6:0] c_opc_lui   = 7'b0110111;
  localparam logic [6:0] c_opc_auipc = 7'b0010111;

  localparam logic [6:0] c_f7_base = 7'b0000000;
  localparam logic [6:0] c_f7_alt  = 7'b0100000;

  // Buffer entry payload: {a, b, op, rd, pc, illegal}
  localparam int c_pl_w = 3 * DATA_WIDTH + ALU_OP_WIDTH + 5 + 1;
  localparam logic [c_pl_w-1:0] c_m_rst = {{DATA_WIDTH{1'b0}}, {DATA_WIDTH{1'b0}},
                                           c_alu_add, 5'd0, RESET_PC_TAG, 1'b0};

  // funct3 -> base ALU op (the ADD/SUB and SRL/SRA split is resolved by funct7)
  function automatic logic [ALU_OP_WIDTH-1:0] f3_op(input logic [2:0] f3);
    logic [ALU_OP_WIDTH-1:0] op;
    case (f3)
      3'b000:  op = c_alu_add;
      3'b001:  op = c_alu_sll;
      3'b010:  op = c_alu_slt;
      3'b011:  op = c_alu_sltu;
      3'b100:  op = c_alu_xor;
      3'b101:  op = c_alu_srl;
      3'b110:  op = c_alu_or;
      default: op = c_alu_and;
    endcase
    return op;
  endfunction

  // --------------------------------------------------------------------------
  // Register file addresses come straight off the incoming word so the read
  // data is available in the same (accept) cycle.
  // --------------------------------------------------------------------------
  assign rs1_addr_o = instr_i[19:15];
  assign rs2_addr_o = instr_i[24:20];

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [6:0]              w_opcode;
  logic [2:0]              w_f3;
  logic [6:0]              w_f7;
  logic [DATA_WIDTH-1:0]   w_imm_i;
  logic [DATA_WIDTH-1:0]   w_imm_u;
  logic [DATA_WIDTH-1:0]   w_a;
  logic [DATA_WIDTH-1:0]   w_b;
  logic [ALU_OP_WIDTH-1:0] w_op;
  logic [4:0]              w_rd;
  logic                    w_ill;
  logic [c_pl_w-1:0]       w_dec_pl;

  assign w_opcode = instr_i[6:0];
  assign w_f3     = instr_i[14:12];
  assign w_f7     = instr_i[31:25];
  assign w_imm_i  = DATA_WIDTH'($signed(instr_i[31:20]));
  assign w_imm_u  = DATA_WIDTH'($signed({instr_i[31:12], 12'h000}));

  always_comb begin
    w_ill = 1'b0;
    w_op  = c_alu_add;
    w_a   = '0;
    w_b   = '0;
    w_rd  = instr_i[11:7];
    case (w_opcode)
      c_opc_op: begin
        w_a = rs1_data_i;
        w_b = rs2_data_i;
        w_op = f3_op(w_f3);
        // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding
        if (w_f7 == c_f7_alt && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
          w_op = (w_f3 == 3'b000) ? c_alu_sub : c_alu_sra;
        end else if (w_f7 != c_f7_base) begin
          w_ill = 1'b1;
        end
      end
      c_opc_imm: begin
        w_a  = rs1_data_i;
        w_b  = w_imm_i;
        w_op = f3_op(w_f3);
        // Shift-immediates reuse imm[11:5] as funct7; all others are plain imm
        if (w_f3 == 3'b001) begin
          if (w_f7 != c_f7_base) begin
            w_ill = 1'b1;
          end
        end else if (w_f3 == 3'b101) begin
          if (w_f7 == c_f7_alt) begin
            w_op = c_alu_sra;
          end else if (w_f7 != c_f7_base) begin
            w_ill = 1'b1;
          end
        end
      end
      c_opc_lui: begin
        w_b = w_imm_u;
      end
      c_opc_auipc: begin
        w_a = pc_i;
        w_b = w_imm_u;
      end
      default: begin
        w_ill = 1'b1;
      end
    endcase
    // Undecodable words issue as a harmless ADD 0+0 to x0 with the flag set
    if (w_ill) begin
      w_op = c_alu_add;
      w_a  = '0;
      w_b  = '0;
      w_rd = 5'd0;
    end
  end

  assign w_dec_pl = {w_a, w_b, w_op, w_rd, pc_i, w_ill};

  // --------------------------------------------------------------------------
  // Two-entry skid buffer: M drives the outputs, S absorbs the one extra
  // accept that can land after ready was registered high.
  // --------------------------------------------------------------------------
  logic              r_m_valid;
  logic              r_s_valid;
  logic [c_pl_w-1:0] r_m_pl;
  logic [c_pl_w-1:0] r_s_pl;
  logic              r_ready;

  logic              w_accept;
  logic              w_consume;
  logic              w_m_free;
  logic              w_m_valid_n;
  logic              w_s_valid_n;
  logic [c_pl_w-1:0] w_m_pl_n;
  logic [c_pl_w-1:0] w_s_pl_n;

  assign w_accept  = instr_valid_i & r_ready;
  assign w_consume = r_m_valid & ex_ready_i;
  assign w_m_free  = ~r_m_valid | w_consume;

  always_comb begin
    w_m_valid_n = r_m_valid;
    w_s_valid_n = r_s_valid;
    w_m_pl_n    = r_m_pl;
    w_s_pl_n    = r_s_pl;
    if (flush_i) begin
      // Flush wins over every move; an entry accepted now is dropped
      w_m_valid_n = 1'b0;
      w_s_valid_n = 1'b0;
    end else if (w_accept) begin
      if (w_m_free) begin
        w_m_valid_n = 1'b1;
        if (r_s_valid) begin
          // Older S entry must leave first to preserve order
          w_m_pl_n = r_s_pl;
          w_s_pl_n = w_dec_pl;
        end else begin
          w_m_pl_n = w_dec_pl;
        end
      end else begin
        w_s_valid_n = 1'b1;
        w_s_pl_n    = w_dec_pl;
      end
    end else if (w_consume) begin
      if (r_s_valid) begin
        w_m_pl_n    = r_s_pl;
        w_s_valid_n = 1'b0;
      end else begin
        w_m_valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_pl    <= c_m_rst;
      r_s_pl    <= '0;
      r_ready   <= 1'b1;
    end else begin
      r_m_valid <= w_m_valid_n;
      r_s_valid <= w_s_valid_n;
      r_m_pl    <= w_m_pl_n;
      r_s_pl    <= w_s_pl_n;
      // Ready only while the skid slot is free next cycle
      r_ready   <= ~w_s_valid_n;
    end
  end

  assign instr_ready_o = r_ready;
  assign ex_valid_o    = r_m_valid;
  assign {alu_a_o, alu_b_o, alu_op_o, rd_addr_o, pc_o, illegal_o} = r_m_pl;

endmodule
`default_nettype wire
